// File: rtl/io_responder.sv
// io_responder: processor I/O handshake block.
// Latches a 15-bit switch value on a push-button press (four-phase in_ready
// acknowledge) and converts a 32-bit value to eight blanked 7-segment digits
// via a 32-cycle shift-add-3 conversion (out_busy acknowledge).
// Optional feature macro: IO_DEBOUNCE_EN adds a counter filter after the
// insert synchroniser; without it DEBOUNCE_CYCLES is unused.
module io_responder #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        input_flag,
  input  logic        output_flag,
  input  logic [31:0] out_data,
  input  logic        insert,
  input  logic [14:0] SW,
  output logic [31:0] user_input,
  output logic        in_ready,
  output logic        out_busy,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic [6:0]  HEX6,
  output logic [6:0]  HEX7
);

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned SW_W     = 15;
  localparam int unsigned DIGITS   = 8;
  localparam int unsigned SEG_W    = 7;
  localparam int unsigned ITER_W   = 6;
  localparam logic [SEG_W-1:0]  SEG_BLANK = 7'h7F;
  localparam logic [SEG_W-1:0]  SEG_ZERO  = 7'h40;
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(DATA_W);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PRESS,
    IN_ACK,
    CONVERT,
    OUT_ACK
  } state_e;

  state_e                   state_q, state_d;
  logic [DATA_W-1:0]        user_input_q, user_input_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_busy_q, out_busy_d;
  logic [DATA_W-1:0]        bin_q, bin_d;
  logic [DATA_W-1:0]        bcd_q, bcd_d;
  logic [ITER_W-1:0]        iter_q, iter_d;
  logic [SEG_W-1:0]         hex_q [DIGITS];
  logic [SEG_W-1:0]         hex_d [DIGITS];

  logic                     meta_q, meta_d;
  logic                     sync_q, sync_d;
  logic                     cond_prev_q, cond_prev_d;
  logic                     cond_c;
  logic                     press_c;

  logic [DATA_W-1:0]        bcd_adj_c;
  logic [DATA_W-1:0]        bcd_shift_c;
  logic [SEG_W-1:0]         disp_c [DIGITS];

  // Active-low 7-segment code, bit 0 = segment a.
  function automatic logic [SEG_W-1:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // Add-3 correction applied to a BCD digit before each shift.
  function automatic logic [3:0] dab(input logic [3:0] d);
    dab = (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // Two-flop synchroniser for the asynchronous button, plus edge history.
  always_comb begin
    meta_d      = insert;
    sync_d      = meta_q;
    cond_prev_d = cond_c;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      meta_q      <= 1'b1;
      sync_q      <= 1'b1;
      cond_prev_q <= 1'b1;
    end else begin
      meta_q      <= meta_d;
      sync_q      <= sync_d;
      cond_prev_q <= cond_prev_d;
    end
  end

`ifdef IO_DEBOUNCE_EN
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic             db_level_q, db_level_d;

  // Accept a new level only after it differs from the filtered one for DEBOUNCE_CYCLES cycles.
  always_comb begin
    db_cnt_d   = '0;
    db_level_d = db_level_q;
    if (sync_q != db_level_q) begin
      if (db_cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        db_level_d = sync_q;
      end else begin
        db_cnt_d = db_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      db_cnt_q   <= '0;
      db_level_q <= 1'b1;
    end else begin
      db_cnt_q   <= db_cnt_d;
      db_level_q <= db_level_d;
    end
  end

  assign cond_c = db_level_q;
`else
  assign cond_c = sync_q;
`endif

  // A press is a falling edge of the conditioned (active-low) button.
  assign press_c = cond_prev_q & ~cond_c;

  // One shift-add-3 step; the bit leaving digit 7 is dropped (mod 10^8).
  always_comb begin
    bcd_adj_c = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      bcd_adj_c[4*i +: 4] = dab(bcd_q[4*i +: 4]);
    end
    bcd_shift_c = DATA_W'({bcd_adj_c, bin_q[DATA_W-1]});
  end

  // Segment image of the finished BCD value with leading-zero blanking.
  always_comb begin
    logic nonzero;
    nonzero = 1'b0;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      nonzero   = nonzero | (bcd_q[4*i +: 4] != 4'd0);
      disp_c[i] = nonzero ? seg7(bcd_q[4*i +: 4]) : SEG_BLANK;
    end
    disp_c[0] = seg7(bcd_q[3:0]);
  end

  // Next-state and datapath control.
  always_comb begin
    state_d      = state_q;
    user_input_d = user_input_q;
    in_ready_d   = in_ready_q;
    out_busy_d   = out_busy_q;
    bin_d        = bin_q;
    bcd_d        = bcd_q;
    iter_d       = iter_q;
    hex_d        = hex_q;
    case (state_q)
      IDLE: begin
        if (input_flag) begin
          state_d = WAIT_PRESS;
        end else if (output_flag) begin
          state_d    = CONVERT;
          bin_d      = out_data;
          bcd_d      = '0;
          iter_d     = '0;
          out_busy_d = 1'b1;
        end
      end
      WAIT_PRESS: begin
        if (press_c) begin
          state_d      = IN_ACK;
          user_input_d = DATA_W'(SW);
          in_ready_d   = 1'b1;
        end
      end
      IN_ACK: begin
        if (!input_flag) begin
          state_d    = IDLE;
          in_ready_d = 1'b0;
        end
      end
      CONVERT: begin
        if (iter_q == LAST_ITER) begin
          state_d    = OUT_ACK;
          hex_d      = disp_c;
          out_busy_d = 1'b0;
        end else begin
          bcd_d  = bcd_shift_c;
          bin_d  = {bin_q[DATA_W-2:0], 1'b0};
          iter_d = iter_q + ITER_W'(1);
        end
      end
      OUT_ACK: begin
        if (!output_flag) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      user_input_q <= '0;
      in_ready_q   <= 1'b0;
      out_busy_q   <= 1'b0;
      bin_q        <= '0;
      bcd_q        <= '0;
      iter_q       <= '0;
      hex_q        <= '{0: SEG_ZERO, default: SEG_BLANK};
    end else begin
      state_q      <= state_d;
      user_input_q <= user_input_d;
      in_ready_q   <= in_ready_d;
      out_busy_q   <= out_busy_d;
      bin_q        <= bin_d;
      bcd_q        <= bcd_d;
      iter_q       <= iter_d;
      hex_q        <= hex_d;
    end
  end

  assign user_input = user_input_q;
  assign in_ready   = in_ready_q;
  assign out_busy   = out_busy_q;
  assign HEX0       = hex_q[0];
  assign HEX1       = hex_q[1];
  assign HEX2       = hex_q[2];
  assign HEX3       = hex_q[3];
  assign HEX4       = hex_q[4];
  assign HEX5       = hex_q[5];
  assign HEX6       = hex_q[6];
  assign HEX7       = hex_q[7];

  logic unused_sw_width;
  assign unused_sw_width = (SW_W == 15) ? 1'b0 : 1'b1;

endmodule

// File: tb/tb_io_responder.sv
// Testbench for io_responder (DEBOUNCE_CYCLES = 4). Works with or without
// IO_DEBOUNCE_EN; the glitch scenario runs only when the macro is defined.
module tb_io_responder;

  logic        CLK = 1'b0;
  logic        reset;
  logic        input_flag;
  logic        output_flag;
  logic [31:0] out_data;
  logic        insert;
  logic [14:0] SW;
  logic [31:0] user_input;
  logic        in_ready;
  logic        out_busy;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_user_input = 32'h0;

  io_responder #(.DEBOUNCE_CYCLES(4)) dut (
    .CLK(CLK), .reset(reset), .input_flag(input_flag), .output_flag(output_flag),
    .out_data(out_data), .insert(insert), .SW(SW), .user_input(user_input),
    .in_ready(in_ready), .out_busy(out_busy),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
    .HEX4(HEX4), .HEX5(HEX5), .HEX6(HEX6), .HEX7(HEX7)
  );

  always #5 CLK = ~CLK;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  function automatic logic [6:0] model_seg(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Expected digit idx of (v mod 10^8) in decimal, leading zeros blanked.
  function automatic logic [6:0] model_hex(input logic [31:0] v, input int idx);
    longint unsigned m = longint'(v) % 64'd100000000;
    longint unsigned p = 1;
    for (int i = 0; i < idx; i++) p = p * 10;
    if (idx > 0 && m < p) return 7'h7F;
    return model_seg(int'((m / p) % 10));
  endfunction

  function automatic logic [6:0] dut_hex(input int idx);
    case (idx)
      0: return HEX0;
      1: return HEX1;
      2: return HEX2;
      3: return HEX3;
      4: return HEX4;
      5: return HEX5;
      6: return HEX6;
      default: return HEX7;
    endcase
  endfunction

  task automatic wait_ready(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (in_ready) begin
        seen = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  task automatic wait_not_busy(input int budget, output int n);
    n = 1;
    for (int i = 0; i < budget && out_busy; i++) begin
      step(1);
      if (out_busy) n++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    input_flag = 1'b0; output_flag = 1'b0; out_data = '0; insert = 1'b1; SW = '0;
    step(2);
    checks++;
    if (user_input !== 32'h0 || in_ready !== 1'b0 || out_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got ui=%h rdy=%b busy=%b exp 0/0/0", user_input, in_ready, out_busy);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dut_hex(i) !== ((i == 0) ? 7'h40 : 7'h7F)) begin
        errors++;
        $display("FAIL reset_hex%0d got %h exp %h", i, dut_hex(i), (i == 0) ? 7'h40 : 7'h7F);
      end
    end
    reset = 1'b0;
    step(3);
  endtask

  task automatic test_input;
    bit seen;
    logic [14:0] sw;
    for (int k = 0; k < 6; k++) begin
      sw = (k == 0) ? 15'h1234 : 15'($urandom);
      SW = sw;
      input_flag = 1'b1;
      step($urandom_range(1, 5));
      insert = 1'b0;
      wait_ready(40, seen);
      model_user_input = {17'b0, sw};
      checks++;
      if (!seen || user_input !== model_user_input) begin
        errors++;
        $display("FAIL input_latch k=%0d got rdy=%b ui=%h exp 1/%h", k, seen, user_input, model_user_input);
      end
      SW = ~sw;
      step($urandom_range(2, 6));
      insert = 1'b1;
      step(12);
      checks++;
      if (in_ready !== 1'b1 || user_input !== model_user_input) begin
        errors++;
        $display("FAIL input_hold k=%0d got rdy=%b ui=%h exp 1/%h", k, in_ready, user_input, model_user_input);
      end
      input_flag = 1'b0;
      step(1);
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL input_release k=%0d got rdy=%b exp 0", k, in_ready);
      end
      step(3);
    end
  endtask

  task automatic test_held_press;
    bit seen;
    SW = 15'($urandom);
    insert = 1'b0;
    step(15);
    input_flag = 1'b1;
    step(20);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL held_press_ignored got rdy=%b exp 0", in_ready);
    end
    insert = 1'b1;
    step(15);
    checks++;
    if (in_ready !== 1'b0 || user_input !== model_user_input) begin
      errors++;
      $display("FAIL held_release got rdy=%b ui=%h exp 0/%h", in_ready, user_input, model_user_input);
    end
    insert = 1'b0;
    wait_ready(40, seen);
    model_user_input = {17'b0, SW};
    checks++;
    if (!seen || user_input !== model_user_input) begin
      errors++;
      $display("FAIL held_repress got rdy=%b ui=%h exp 1/%h", seen, user_input, model_user_input);
    end
    insert = 1'b1;
    input_flag = 1'b0;
    step(12);
  endtask

  task automatic test_convert;
    logic [31:0] vals [12];
    logic [31:0] prev;
    int n;
    vals[0] = 32'd1234;     vals[1] = 32'hFFFFFFFF; vals[2] = 32'd0;
    vals[3] = 32'd99999999; vals[4] = 32'd100000000; vals[5] = 32'd10;
    for (int k = 6; k < 12; k++) vals[k] = $urandom;
    prev = 32'd0;
    for (int k = 0; k < 12; k++) begin
      out_data = vals[k];
      output_flag = 1'b1;
      step(1);
      out_data = $urandom;
      checks++;
      if (out_busy !== 1'b1) begin
        errors++;
        $display("FAIL convert_start v=%h got busy=%b exp 1", vals[k], out_busy);
      end
      step(5);
      checks++;
      if (HEX0 !== model_hex(prev, 0)) begin
        errors++;
        $display("FAIL convert_hold_display v=%h got %h exp %h", vals[k], HEX0, model_hex(prev, 0));
      end
      out_data = $urandom;
      wait_not_busy(100, n);
      n = n + 5;
      checks++;
      if (n != 33) begin
        errors++;
        $display("FAIL convert_busy_len v=%h got %0d exp 33", vals[k], n);
      end
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (dut_hex(i) !== model_hex(vals[k], i)) begin
          errors++;
          $display("FAIL convert_hex%0d v=%h got %h exp %h", i, vals[k], dut_hex(i), model_hex(vals[k], i));
        end
      end
      prev = vals[k];
      output_flag = 1'b0;
      step(2);
    end
  endtask

  task automatic test_priority;
    bit seen;
    int n;
    logic [31:0] v;
    v = $urandom;
    SW = 15'($urandom);
    out_data = v;
    input_flag = 1'b1;
    output_flag = 1'b1;
    step(6);
    checks++;
    if (out_busy !== 1'b0) begin
      errors++;
      $display("FAIL prio_no_convert got busy=%b exp 0", out_busy);
    end
    insert = 1'b0;
    wait_ready(40, seen);
    model_user_input = {17'b0, SW};
    checks++;
    if (!seen || user_input !== model_user_input) begin
      errors++;
      $display("FAIL prio_input got rdy=%b ui=%h exp 1/%h", seen, user_input, model_user_input);
    end
    insert = 1'b1;
    step(8);
    input_flag = 1'b0;
    step(1);
    checks++;
    if (in_ready !== 1'b0 || out_busy !== 1'b0) begin
      errors++;
      $display("FAIL prio_ack got rdy=%b busy=%b exp 0/0", in_ready, out_busy);
    end
    step(1);
    checks++;
    if (out_busy !== 1'b1) begin
      errors++;
      $display("FAIL prio_convert_start got busy=%b exp 1", out_busy);
    end
    wait_not_busy(100, n);
    checks++;
    if (n != 33) begin
      errors++;
      $display("FAIL prio_busy_len got %0d exp 33", n);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dut_hex(i) !== model_hex(v, i)) begin
        errors++;
        $display("FAIL prio_hex%0d got %h exp %h", i, dut_hex(i), model_hex(v, i));
      end
    end
    output_flag = 1'b0;
    step(2);
  endtask

  task automatic test_reset_mid_convert;
    out_data = 32'd87654321;
    output_flag = 1'b1;
    step(11);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out_busy !== 1'b0 || in_ready !== 1'b0 || user_input !== 32'h0 || HEX0 !== 7'h40) begin
      errors++;
      $display("FAIL reset_mid_convert got busy=%b rdy=%b ui=%h hex0=%h exp 0/0/0/40", out_busy, in_ready, user_input, HEX0);
    end
    model_user_input = 32'h0;
    output_flag = 1'b0;
    step(2);
    reset = 1'b0;
    step(40);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dut_hex(i) !== ((i == 0) ? 7'h40 : 7'h7F)) begin
        errors++;
        $display("FAIL reset_no_restore_hex%0d got %h exp %h", i, dut_hex(i), (i == 0) ? 7'h40 : 7'h7F);
      end
    end
    checks++;
    if (out_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_after_busy got %b exp 0", out_busy);
    end
  endtask

  task automatic test_reset_wait_press;
    bit seen;
    SW = 15'h7ABC;
    input_flag = 1'b1;
    step(2);
    insert = 1'b0;
    wait_ready(40, seen);
    insert = 1'b1;
    step(10);
    input_flag = 1'b0;
    step(3);
    checks++;
    if (!seen || user_input !== 32'h00007ABC) begin
      errors++;
      $display("FAIL wp_setup got rdy=%b ui=%h exp 1/00007abc", seen, user_input);
    end
    SW = 15'h0555;
    input_flag = 1'b1;
    step(3);
    insert = 1'b0;
    step(1);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || user_input !== 32'h0) begin
      errors++;
      $display("FAIL reset_wait_press got rdy=%b ui=%h exp 0/0", in_ready, user_input);
    end
    input_flag = 1'b0;
    insert = 1'b1;
    step(2);
    reset = 1'b0;
    step(15);
    checks++;
    if (in_ready !== 1'b0 || user_input !== 32'h0) begin
      errors++;
      $display("FAIL reset_wait_press_after got rdy=%b ui=%h exp 0/0", in_ready, user_input);
    end
  endtask

`ifdef IO_DEBOUNCE_EN
  task automatic test_debounce;
    bit seen;
    SW = 15'($urandom);
    input_flag = 1'b1;
    step(3);
    insert = 1'b0;
    step(2);
    insert = 1'b1;
    step(20);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL debounce_glitch got rdy=%b exp 0", in_ready);
    end
    insert = 1'b0;
    wait_ready(40, seen);
    checks++;
    if (!seen || user_input !== {17'b0, SW}) begin
      errors++;
      $display("FAIL debounce_press got rdy=%b ui=%h exp 1/%h", seen, user_input, {17'b0, SW});
    end
    insert = 1'b1;
    input_flag = 1'b0;
    step(15);
  endtask
`endif

  initial begin
    test_reset();
    test_input();
    test_held_press();
    test_convert();
    test_priority();
`ifdef IO_DEBOUNCE_EN
    test_debounce();
`endif
    test_reset_mid_convert();
    test_reset_wait_press();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
